mem_ctrl: RTL

- Single arbiter between the core's two memory clients and the byte-wide RAM/IO port.
- Clients: instruction fetch (4-byte reads) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each request into per-byte RAM cycles, assembles little-endian read data and returns a one-cycle done pulse.
- Sits directly downstream of the load/store buffer: consumes its memory request fields and drives its completion flag and data.

---
 rtl/mem_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory arbiter: serves instruction fetch and load/store buffer
// requests over a byte-wide RAM/IO port with 1-cycle read latency.
module mem_ctrl #(
    parameter int         ADDR_W     = 32,
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_ins,
    input  logic              lsb_req,
    input  logic              lsb_type,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [1:0]        lsb_len,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              io_q, io_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_ins_q, if_ins_d;
    logic              lsb_done_q, lsb_done_d;
    logic [31:0]       lsb_rdata_q, lsb_rdata_d;

    logic [2:0] lsb_n;
    logic [4:0] rd_off;
    logic [4:0] wr_off;
    logic       accept_ok;
    logic       lsb_is_io;

    always_comb begin
        case (lsb_len)
            2'b01:   lsb_n = 3'd2;
            2'b11:   lsb_n = 3'd4;
            default: lsb_n = 3'd1;
        endcase
    end

    // Read data for byte i arrives one edge after its address, so the byte
    // being captured is always one behind the counter.
    assign rd_off    = {cnt_q[1:0] - 2'd1, 3'b000};
    assign wr_off    = {cnt_q[1:0], 3'b000};
    assign accept_ok = !clear && !if_done_q && !lsb_done_q;
    assign lsb_is_io = (lsb_addr[17:16] == IO_ADDR_HI);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        io_d        = io_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_done_d   = if_done_q;
        if_ins_d    = if_ins_q;
        lsb_done_d  = lsb_done_q;
        lsb_rdata_d = lsb_rdata_q;

        if (ready) begin
            if_done_d  = 1'b0;
            lsb_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    mem_a_d  = '0;
                    mem_wr_d = 1'b0;
                    if (accept_ok && lsb_req) begin
                        base_d  = lsb_addr;
                        len_d   = lsb_n;
                        cnt_d   = 3'd0;
                        buf_d   = '0;
                        wdata_d = lsb_wdata;
                        io_d    = lsb_is_io;
                        mem_a_d = lsb_addr;
                        if (lsb_type) begin
                            state_d = STORE;
                            if (!(lsb_is_io && io_buffer_full)) begin
                                mem_wr_d   = 1'b1;
                                mem_dout_d = lsb_wdata[7:0];
                                cnt_d      = 3'd1;
                            end
                        end else begin
                            state_d = LOAD;
                        end
                    end else if (accept_ok && if_req) begin
                        state_d = FETCH;
                        base_d  = if_addr;
                        len_d   = 3'd4;
                        cnt_d   = 3'd0;
                        buf_d   = '0;
                        io_d    = 1'b0;
                        mem_a_d = if_addr;
                    end
                end
                FETCH, LOAD: begin
                    if (clear) begin
                        state_d = IDLE;
                        mem_a_d = '0;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            buf_d[rd_off +: 8] = mem_din;
                        end
                        if (cnt_q == len_q) begin
                            state_d = IDLE;
                            mem_a_d = '0;
                            if (state_q == FETCH) begin
                                if_done_d = 1'b1;
                                if_ins_d  = buf_d;
                            end else begin
                                lsb_done_d  = 1'b1;
                                lsb_rdata_d = buf_d;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            if ((cnt_q + 3'd1) < len_q) begin
                                mem_a_d = base_q + ADDR_W'(cnt_q + 3'd1);
                            end
                        end
                    end
                end
                STORE: begin
                    // Committed stores ignore clear and always run to completion.
                    if (cnt_q == len_q) begin
                        state_d    = IDLE;
                        mem_a_d    = '0;
                        mem_wr_d   = 1'b0;
                        lsb_done_d = 1'b1;
                    end else if (io_q && io_buffer_full) begin
                        mem_wr_d = 1'b0;
                    end else begin
                        mem_a_d    = base_q + ADDR_W'(cnt_q);
                        mem_dout_d = wdata_q[wr_off +: 8];
                        mem_wr_d   = 1'b1;
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    mem_a_d  = '0;
                    mem_wr_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            io_q        <= 1'b0;
            buf_q       <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_ins_q    <= '0;
            lsb_done_q  <= 1'b0;
            lsb_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            io_q        <= io_d;
            buf_q       <= buf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            if_ins_q    <= if_ins_d;
            lsb_done_q  <= lsb_done_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign if_done   = if_done_q;
    assign if_ins    = if_ins_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule
